// File: rtl/axi_wr_pkg.sv
// Shared AXI4 write-path types for the per-slave-port write arbiter/mux.
// No logic: struct widths are fixed by the package constants below.
// Flow control is carried on separate VALID/READY signals alongside these payloads.
package axi_wr_pkg;

  localparam int DEF_NUM_MASTERS = 4;
  localparam int DATA_WIDTH      = 1024;
  localparam int ADDR_WIDTH      = 64;
  localparam int ID_WIDTH        = 8;
  localparam int USER_WIDTH      = 8;
  localparam int STRB_WIDTH      = DATA_WIDTH / 8;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  lock;
    logic [3:0]            cache;
    logic [2:0]            prot;
    logic [3:0]            qos;
    logic [3:0]            region;
    logic [USER_WIDTH-1:0] user;
  } aw_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;
    logic                  last;
    logic [USER_WIDTH-1:0] user;
  } w_t;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_ADDR = 2'd1,
    WR_DATA = 2'd2,
    WR_RESP = 2'd3
  } wr_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: one-hot grant to the first requester after last_grant.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the grant is consumed.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant
);

  logic [IDX_W-1:0] idx;
  logic             found;

  // Walk the ring starting one past the previous winner, wrapping N-1 -> 0.
  always_comb begin
    grant = '0;
    idx   = last_grant;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (idx == IDX_W'(N - 1)) idx = '0;
      else                      idx = idx + IDX_W'(1);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_wr_master_arb_mux.sv
// N-master to 1-slave AXI4 write arbiter/mux with grant held from AW through B.
// Latency: AWVALID in IDLE at cycle t -> s_AWVALID at t+1; W and B paths are combinational.
// Backpressure: slave READYs pass straight to the granted master only; others see READY=0.
module axi_wr_master_arb_mux
  import axi_wr_pkg::*;
#(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  input  aw_t                    m_aw [NUM_MASTERS],
  input  logic [NUM_MASTERS-1:0] m_AWVALID,
  output logic [NUM_MASTERS-1:0] m_AWREADY,
  input  w_t                     m_w [NUM_MASTERS],
  input  logic [NUM_MASTERS-1:0] m_WVALID,
  output logic [NUM_MASTERS-1:0] m_WREADY,
  output logic [NUM_MASTERS-1:0] m_BVALID,
  input  logic [NUM_MASTERS-1:0] m_BREADY,
  output aw_t                    s_aw,
  output logic                   s_AWVALID,
  input  logic                   s_AWREADY,
  output w_t                     s_w,
  output logic                   s_WVALID,
  input  logic                   s_WREADY,
  input  logic                   s_BVALID,
  output logic                   s_BREADY,
  output logic [NUM_MASTERS-1:0] wgrnt,
  output logic                   err_wlast
);

  localparam int IDX_W = $clog2(NUM_MASTERS);

  wr_state_e              state_q, state_d;
  logic [NUM_MASTERS-1:0] wgrnt_q, wgrnt_d, arb_grant;
  logic [IDX_W-1:0]       last_grant_q, last_grant_d, g_idx;
  logic [7:0]             len_q, len_d, beat_cnt_q, beat_cnt_d;
  logic                   in_addr, in_data, in_resp;
  logic                   aw_hs, w_hs, b_hs, last_beat;

  rr_arbiter #(.N(NUM_MASTERS), .IDX_W(IDX_W)) u_rr_arbiter (
    .req        (m_AWVALID),
    .last_grant (last_grant_q),
    .grant      (arb_grant)
  );

  // Binary index of the registered one-hot grant (0 when idle; gated by state below).
  always_comb begin
    g_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (wgrnt_q[i]) g_idx = IDX_W'(i);
    end
  end

  // Payload mux; an all-zero grant yields all-zero payloads.
  always_comb begin
    s_aw = '0;
    s_w  = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (wgrnt_q[i]) begin
        s_aw = m_aw[i];
        s_w  = m_w[i];
      end
    end
  end

  assign in_addr = (state_q == WR_ADDR);
  assign in_data = (state_q == WR_DATA);
  assign in_resp = (state_q == WR_RESP);

  assign s_AWVALID = in_addr & m_AWVALID[g_idx];
  assign s_WVALID  = in_data & m_WVALID[g_idx];
  assign s_BREADY  = in_resp & m_BREADY[g_idx];

  assign m_AWREADY = wgrnt_q & {NUM_MASTERS{in_addr & s_AWREADY}};
  assign m_WREADY  = wgrnt_q & {NUM_MASTERS{in_data & s_WREADY}};
  assign m_BVALID  = wgrnt_q & {NUM_MASTERS{in_resp & s_BVALID}};

  assign aw_hs     = s_AWVALID & s_AWREADY;
  assign w_hs      = s_WVALID & s_WREADY;
  assign b_hs      = s_BVALID & s_BREADY;
  assign last_beat = (beat_cnt_q == len_q);

  // WLAST is only monitored; the burst length always comes from the latched AWLEN.
  assign err_wlast = w_hs & (s_w.last ^ last_beat);
  assign wgrnt     = wgrnt_q;

  // Next-state logic: grant on request, lock through AW/W/B, release after B.
  always_comb begin
    state_d      = state_q;
    wgrnt_d      = wgrnt_q;
    last_grant_d = last_grant_q;
    len_d        = len_q;
    beat_cnt_d   = beat_cnt_q;
    case (state_q)
      WR_IDLE: begin
        if (|m_AWVALID) begin
          wgrnt_d = arb_grant;
          state_d = WR_ADDR;
        end
      end
      WR_ADDR: begin
        if (aw_hs) begin
          len_d      = s_aw.len;
          beat_cnt_d = '0;
          state_d    = WR_DATA;
        end
      end
      WR_DATA: begin
        if (w_hs) begin
          // LEN=255 gives 256 beats; the counter wraps only on the final beat.
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (last_beat) state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (b_hs) begin
          last_grant_d = g_idx;
          wgrnt_d      = '0;
          state_d      = WR_IDLE;
        end
      end
      default: state_d = WR_IDLE;
    endcase
  end

  // State registers; reset drops any in-flight burst immediately.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q      <= WR_IDLE;
      wgrnt_q      <= '0;
      last_grant_q <= IDX_W'(NUM_MASTERS - 1);
      len_q        <= '0;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      wgrnt_q      <= wgrnt_d;
      last_grant_q <= last_grant_d;
      len_q        <= len_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_axi_wr_master_arb_mux.sv
module tb_axi_wr_master_arb_mux;
  import axi_wr_pkg::*;

  localparam int N = 4;

  logic         ACLK    = 1'b0;
  logic         ARESETn = 1'b0;
  aw_t          m_aw [N];
  logic [N-1:0] m_AWVALID, m_AWREADY;
  w_t           m_w [N];
  logic [N-1:0] m_WVALID, m_WREADY, m_BVALID, m_BREADY;
  aw_t          s_aw;
  logic         s_AWVALID, s_AWREADY;
  w_t           s_w;
  logic         s_WVALID, s_WREADY, s_BVALID, s_BREADY;
  logic [N-1:0] wgrnt;
  logic         err_wlast;

  axi_wr_master_arb_mux #(.NUM_MASTERS(N)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .m_aw(m_aw), .m_AWVALID(m_AWVALID), .m_AWREADY(m_AWREADY),
    .m_w(m_w), .m_WVALID(m_WVALID), .m_WREADY(m_WREADY),
    .m_BVALID(m_BVALID), .m_BREADY(m_BREADY),
    .s_aw(s_aw), .s_AWVALID(s_AWVALID), .s_AWREADY(s_AWREADY),
    .s_w(s_w), .s_WVALID(s_WVALID), .s_WREADY(s_WREADY),
    .s_BVALID(s_BVALID), .s_BREADY(s_BREADY),
    .wgrnt(wgrnt), .err_wlast(err_wlast)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [3:0] awv, wv, wl, br;
    logic       s_awr, s_wr, s_bv;
    logic [3:0] e_grnt;
    logic       e_sawv, e_swv, e_sbr;
    logic [3:0] e_awr, e_wr, e_bv;
    logic       e_err;
  } vec_t;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] lens [N];
  vec_t       vecs [$];

  function automatic vec_t mk(input logic [3:0] awv, wv, wl, br,
                              input logic sawr, swr, sbv,
                              input logic [3:0] eg,
                              input logic esawv, eswv, esbr,
                              input logic [3:0] eawr, ewr, ebv,
                              input logic eerr);
    vec_t v;
    v.awv = awv; v.wv = wv; v.wl = wl; v.br = br;
    v.s_awr = sawr; v.s_wr = swr; v.s_bv = sbv;
    v.e_grnt = eg; v.e_sawv = esawv; v.e_swv = eswv; v.e_sbr = esbr;
    v.e_awr = eawr; v.e_wr = ewr; v.e_bv = ebv; v.e_err = eerr;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_payload();
    for (int i = 0; i < N; i++) begin
      m_aw[i]       = '0;
      m_aw[i].id    = 8'(i + 1);
      m_aw[i].addr  = 64'(i + 1) << 12;
      m_aw[i].len   = lens[i];
      m_aw[i].size  = 3'd7;
      m_aw[i].burst = 2'b01;
      m_w[i]        = '0;
      m_w[i].id     = 8'(i + 1);
      m_w[i].data   = {32{32'hD000_0000 + 32'(i)}};
      m_w[i].strb   = '1;
    end
  endtask

  task automatic do_reset();
    ARESETn   = 1'b0;
    m_AWVALID = '0; m_WVALID = '0; m_BREADY = '0;
    s_AWREADY = 1'b0; s_WREADY = 1'b0; s_BVALID = 1'b0;
    for (int i = 0; i < N; i++) m_w[i].last = 1'b0;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(posedge ACLK);
    #1;
  endtask

  task automatic wait_grant(output logic [3:0] g);
    g = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge ACLK);
      if (wgrnt != 4'b0000) begin
        g = wgrnt;
        break;
      end
    end
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 20; c++) begin
      @(negedge ACLK);
      if (wgrnt == 4'b0000) break;
    end
  endtask

  task automatic apply(input vec_t v);
    m_AWVALID = v.awv; m_WVALID = v.wv; m_BREADY = v.br;
    for (int i = 0; i < N; i++) m_w[i].last = v.wl[i];
    s_AWREADY = v.s_awr; s_WREADY = v.s_wr; s_BVALID = v.s_bv;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]   g;
    logic [3:0]   rr_exp [5];
    logic [19:0]  act, exp;
    logic [127:0] act_p, exp_p;
    int           viol, beat, recv, errs;
    logic         wrdy, mhs;

    for (int i = 0; i < N; i++) lens[i] = 8'd0;
    lens[1] = 8'd3;
    set_payload();
    do_reset();

    // Reset state: idle, nothing granted, every handshake output low.
    @(negedge ACLK);
    check("reset_state", {wgrnt, s_AWVALID, s_WVALID, s_BREADY, m_AWREADY, m_WREADY, m_BVALID, err_wlast}, '0);
    @(posedge ACLK); #1;

    // m1 LEN=3 clean burst, then m1 LEN=3 with early WLAST and stalls.
    vecs.push_back(mk(4'b0010,4'b0000,4'b0000,4'b0000, 1'b1,1'b1,1'b0, 4'b0000, 1'b0,1'b0,1'b0, 4'b0000,4'b0000,4'b0000, 1'b0));
    vecs.push_back(mk(4'b0010,4'b0010,4'b0000,4'b0000, 1'b1,1'b1,1'b0, 4'b0010, 1'b1,1'b0,1'b0, 4'b0010,4'b0000,4'b0000, 1'b0));
    vecs.push_back(mk(4'b0000,4'b0010,4'b0000,4'b0000, 1'b1,1'b1,1'b0, 4'b0010, 1'b0,1'b1,1'b0, 4'b0000,4'b0010,4'b0000, 1'b0));
    vecs.push_back(mk(4'b0000,4'b0010,4'b0000,4'b0000, 1'b1,1'b1,1'b0, 4'b0010, 1'b0,1'b1,1'b0, 4'b0000,4'b0010,4'b0000, 1'b0));
    vecs.push_back(mk(4'b0000,4'b0010,4'b0000,4'b0000, 1'b1,1'b1,1'b0, 4'b0010, 1'b0,1'b1,1'b0, 4'b0000,4'b0010,4'b0000, 1'b0));
    vecs.push_back(mk(4'b0000,4'b0010,4'b0010,4'b0000, 1'b1,1'b1,1'b0, 4'b0010, 1'b0,1'b1,1'b0, 4'b0000,4'b0010,4'b0000, 1'b0));
    vecs.push_back(mk(4'b0000,4'b0000,4'b0000,4'b1111, 1'b1,1'b1,1'b1, 4'b0010, 1'b0,1'b0,1'b1, 4'b0000,4'b0000,4'b0010, 1'b0));
    vecs.push_back(mk(4'b0000,4'b0000,4'b0000,4'b0000, 1'b1,1'b1,1'b0, 4'b0000, 1'b0,1'b0,1'b0, 4'b0000,4'b0000,4'b0000, 1'b0));
    vecs.push_back(mk(4'b0010,4'b0000,4'b0000,4'b0000, 1'b1,1'b1,1'b0, 4'b0000, 1'b0,1'b0,1'b0, 4'b0000,4'b0000,4'b0000, 1'b0));
    vecs.push_back(mk(4'b0010,4'b0000,4'b0000,4'b0000, 1'b0,1'b1,1'b0, 4'b0010, 1'b1,1'b0,1'b0, 4'b0000,4'b0000,4'b0000, 1'b0));
    vecs.push_back(mk(4'b0010,4'b0000,4'b0000,4'b0000, 1'b1,1'b1,1'b0, 4'b0010, 1'b1,1'b0,1'b0, 4'b0010,4'b0000,4'b0000, 1'b0));
    vecs.push_back(mk(4'b0000,4'b0010,4'b0000,4'b0000, 1'b1,1'b1,1'b0, 4'b0010, 1'b0,1'b1,1'b0, 4'b0000,4'b0010,4'b0000, 1'b0));
    vecs.push_back(mk(4'b0000,4'b0010,4'b0010,4'b0000, 1'b1,1'b1,1'b0, 4'b0010, 1'b0,1'b1,1'b0, 4'b0000,4'b0010,4'b0000, 1'b1));
    vecs.push_back(mk(4'b0000,4'b0010,4'b0000,4'b0000, 1'b1,1'b0,1'b0, 4'b0010, 1'b0,1'b1,1'b0, 4'b0000,4'b0000,4'b0000, 1'b0));
    vecs.push_back(mk(4'b0000,4'b0010,4'b0000,4'b0000, 1'b1,1'b1,1'b0, 4'b0010, 1'b0,1'b1,1'b0, 4'b0000,4'b0010,4'b0000, 1'b0));
    vecs.push_back(mk(4'b0000,4'b0010,4'b0010,4'b0000, 1'b1,1'b1,1'b0, 4'b0010, 1'b0,1'b1,1'b0, 4'b0000,4'b0010,4'b0000, 1'b0));
    vecs.push_back(mk(4'b0000,4'b0010,4'b0000,4'b0010, 1'b1,1'b1,1'b0, 4'b0010, 1'b0,1'b0,1'b1, 4'b0000,4'b0000,4'b0000, 1'b0));
    vecs.push_back(mk(4'b0000,4'b0000,4'b0000,4'b0010, 1'b1,1'b1,1'b1, 4'b0010, 1'b0,1'b0,1'b1, 4'b0000,4'b0000,4'b0010, 1'b0));
    vecs.push_back(mk(4'b0000,4'b0000,4'b0000,4'b0000, 1'b1,1'b1,1'b0, 4'b0000, 1'b0,1'b0,1'b0, 4'b0000,4'b0000,4'b0000, 1'b0));

    for (int k = 0; k < vecs.size(); k++) begin
      apply(vecs[k]);
      @(negedge ACLK);
      act = {wgrnt, s_AWVALID, s_WVALID, s_BREADY, m_AWREADY, m_WREADY, m_BVALID, err_wlast};
      exp = {vecs[k].e_grnt, vecs[k].e_sawv, vecs[k].e_swv, vecs[k].e_sbr,
             vecs[k].e_awr, vecs[k].e_wr, vecs[k].e_bv, vecs[k].e_err};
      check($sformatf("vec%0d", k), 128'(act), 128'(exp));
      exp_p = '0;
      for (int i = 0; i < N; i++) begin
        if (vecs[k].e_grnt[i])
          exp_p = {16'h0, 64'(i + 1) << 12, 32'hD000_0000 + 32'(i), 8'(i + 1), 8'(i + 1)};
      end
      act_p = {16'h0, s_aw.addr, s_w.data[31:0], s_w.id, s_aw.id};
      check($sformatf("vec%0d_payload", k), act_p, exp_p);
      @(posedge ACLK); #1;
    end

    // Round-robin: all four request back-to-back single-beat bursts.
    do_reset();
    for (int i = 0; i < N; i++) lens[i] = 8'd0;
    set_payload();
    for (int i = 0; i < N; i++) m_w[i].last = 1'b1;
    m_AWVALID = '1; m_WVALID = '1; m_BREADY = '1;
    s_AWREADY = 1'b1; s_WREADY = 1'b1; s_BVALID = 1'b1;
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      wait_grant(g);
      check($sformatf("rr%0d", k), 128'(g), 128'(rr_exp[k]));
      wait_idle();
    end

    // Lock: m2 asks while m0 owns the port; m2 must wait for m0's B handshake.
    do_reset();
    lens[0] = 8'd3;
    set_payload();
    s_AWREADY = 1'b1; s_WREADY = 1'b1;
    m_AWVALID = 4'b0001;
    wait_grant(g);
    check("lock_grant", 128'(g), 128'(4'b0001));
    @(posedge ACLK); #1;
    m_AWVALID = 4'b0100; m_WVALID = 4'b0001;
    viol = 0;
    for (int c = 0; c < 9; c++) begin
      if (c == 8) begin s_BVALID = 1'b1; m_BREADY = 4'b0001; end
      @(negedge ACLK);
      if (m_AWREADY[2] !== 1'b0 || wgrnt !== 4'b0001) viol++;
      if (c == 8) check("lock_b_route", 128'(m_BVALID), 128'(4'b0001));
      @(posedge ACLK); #1;
    end
    check("lock_hold", 128'(viol), 128'(0));
    s_BVALID = 1'b0; m_BREADY = '0; m_WVALID = '0;
    wait_grant(g);
    check("lock_next", 128'(g), 128'(4'b0100));
    check("lock_m2_awready", 128'(m_AWREADY), 128'(4'b0100));

    // Backpressure: WREADY toggling, BVALID held off for 5 cycles.
    do_reset();
    lens[1] = 8'd3;
    set_payload();
    m_w[1].data = '0;
    s_AWREADY = 1'b1; m_AWVALID = 4'b0010; m_BREADY = 4'b0010;
    wait_grant(g);
    check("bp_grant", 128'(g), 128'(4'b0010));
    @(posedge ACLK); #1;
    m_AWVALID = '0; m_WVALID = 4'b0010;
    beat = 0; recv = 0; errs = 0; wrdy = 1'b1;
    for (int c = 0; c < 30 && beat < 4; c++) begin
      s_WREADY = wrdy;
      wrdy = ~wrdy;
      m_w[1].data[31:0] = 32'(beat);
      m_w[1].last = (beat == 3);
      @(negedge ACLK);
      if (err_wlast) errs++;
      mhs = m_WVALID[1] & m_WREADY[1];
      if (s_WVALID && s_WREADY) begin
        check($sformatf("bp_data%0d", recv), 128'(s_w.data[31:0]), 128'(recv));
        recv++;
      end
      @(posedge ACLK); #1;
      if (mhs) beat++;
    end
    check("bp_beats", 128'(recv), 128'(4));
    s_WREADY = 1'b1; m_w[1].last = 1'b0; viol = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge ACLK);
      if (s_WVALID || m_WREADY != 4'b0000 || m_BVALID != 4'b0000 || !s_BREADY || wgrnt != 4'b0010) viol++;
      @(posedge ACLK); #1;
    end
    check("bp_resp_wait", 128'(viol), 128'(0));
    s_BVALID = 1'b1;
    @(negedge ACLK);
    check("bp_b", 128'(m_BVALID), 128'(4'b0010));
    @(posedge ACLK); #1;
    s_BVALID = 1'b0; m_WVALID = '0;
    @(negedge ACLK);
    check("bp_idle", 128'(wgrnt), 128'(0));
    check("bp_no_err", 128'(errs), 128'(0));
    @(posedge ACLK); #1;

    // Reset after 2 of 8 beats: everything drops, next grant restarts at m0.
    do_reset();
    lens[2] = 8'd7;
    set_payload();
    s_AWREADY = 1'b1; s_WREADY = 1'b1; m_AWVALID = 4'b0100;
    wait_grant(g);
    check("rst_grant", 128'(g), 128'(4'b0100));
    @(posedge ACLK); #1;
    m_AWVALID = '0; m_WVALID = 4'b0100;
    repeat (2) begin @(posedge ACLK); #1; end
    m_AWVALID = '1; s_BVALID = 1'b1; m_BREADY = '1;
    #1 ARESETn = 1'b0;
    #1;
    check("rst_outputs", 128'({wgrnt, s_AWVALID, s_WVALID, s_BREADY, m_AWREADY, m_WREADY, m_BVALID}), '0);
    check("rst_payload", 128'(s_aw.addr), '0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    wait_grant(g);
    check("rst_next", 128'(g), 128'(4'b0001));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
